// File: rtl/icache_def.sv
// Shared cache/memory interface types plus the memory-arbiter state encodings.
// Pure declarations, no logic, no latency.
// Backpressure is carried in the ready bit of mem_data_type.
package icache_def;

   // Request from a cache controller to main memory.
   typedef struct packed {
      logic [15:0] addr;
      logic [63:0] data;
      logic        rw;
      logic        valid;
   } mem_req_type;

   // Response from main memory to a cache controller.
   typedef struct packed {
      logic [63:0] data;
      logic        ready;
   } mem_data_type;

   // Arbiter ownership of the memory port.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   // Identity of a requester, used for the round-robin pointer.
   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } requester_t;

   // Width of the arbiter watchdog counter.
   localparam int unsigned WDOG_W = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I-cache and D-cache.
// Grant takes one edge; request and response steering are combinational while granted.
// Non-granted side waits holding its request; a hung grant is aborted by the watchdog.
module mem_arbiter
   import icache_def::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  mem_req_type  ic_req,
   input  mem_req_type  dc_req,
   input  mem_data_type mem_res,
   output mem_req_type  mem_req,
   output mem_data_type ic_res,
   output mem_data_type dc_res,
   output logic         busy,
   output logic         timeout_err
);

   // Last watchdog value before abort; TIMEOUT busy cycles in total.
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

   arb_state_t        r_state;
   requester_t        r_last_grant;
   logic [WDOG_W-1:0] r_wdog;
   logic              r_timeout_err;

   mem_req_type       w_gnt_req;
   requester_t        w_owner;
   logic              w_end;

   // Owner of the current grant and its request as seen by the FSM.
   always_comb begin
      w_owner   = (r_state == BUSY_D) ? REQ_D : REQ_I;
      w_gnt_req = (r_state == BUSY_D) ? dc_req : ic_req;
      // Ready takes precedence over a requester dropping valid in the same cycle.
      w_end     = mem_res.ready || !w_gnt_req.valid;
   end

   // Grant FSM with round-robin pointer and watchdog.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_last_grant  <= REQ_D;
         r_wdog        <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_wdog <= '0;
               // A tie goes to the side that did not own the previous grant.
               if (ic_req.valid && (!dc_req.valid || (r_last_grant == REQ_D))) begin
                  r_state <= BUSY_I;
               end else if (dc_req.valid) begin
                  r_state <= BUSY_D;
               end
            end
            BUSY_I, BUSY_D: begin
               if (w_end) begin
                  r_state      <= IDLE;
                  r_last_grant <= w_owner;
                  r_wdog       <= '0;
               end else if (r_wdog == WDOG_LAST) begin
                  // Hung transaction: release the port and leave a sticky flag.
                  r_state       <= IDLE;
                  r_last_grant  <= w_owner;
                  r_wdog        <= '0;
                  r_timeout_err <= 1'b1;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_wdog  <= '0;
            end
         endcase
      end
   end

   // Steer the granted request to memory and the memory response to its owner.
   always_comb begin
      mem_req = '0;
      ic_res  = '0;
      dc_res  = '0;
      case (r_state)
         BUSY_I: begin
            mem_req = ic_req;
            ic_res  = mem_res;
         end
         BUSY_D: begin
            mem_req = dc_req;
            dc_res  = mem_res;
         end
         default: begin
            mem_req = '0;
         end
      endcase
   end

   assign busy        = (r_state != IDLE);
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;
   import icache_def::*;

   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   mem_req_type  ic_req, dc_req, mem_req;
   mem_data_type mem_res, ic_res, dc_res;
   logic         busy, timeout_err;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .ic_req     (ic_req),
      .dc_req     (dc_req),
      .mem_res    (mem_res),
      .mem_req    (mem_req),
      .ic_res     (ic_res),
      .dc_res     (dc_res),
      .busy       (busy),
      .timeout_err(timeout_err)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: who owns the port (0 none, 1 I, 2 D), who won last,
   // how many busy cycles have elapsed, and the sticky error.
   int m_owner, m_last, m_wait, m_side, m_evt;
   bit m_err;

   // DUT observations used by directed scenarios.
   int n_ic_rdy, n_dc_rdy, n_busy, idle_run;
   bit prev_busy, g_started;
   int g_side[$];
   int g_gap[$];

   task automatic model_reset();
      m_owner = 0; m_last = 2; m_wait = 0; m_err = 0; m_evt = 0; m_side = 0;
   endtask

   // Expected outputs follow directly from who owns the port.
   task automatic check_out();
      mem_req_type  e_req;
      mem_data_type e_ic, e_dc;
      e_req = '0; e_ic = '0; e_dc = '0;
      if (m_owner == 1) begin
         e_req = ic_req; e_ic = mem_res;
      end else if (m_owner == 2) begin
         e_req = dc_req; e_dc = mem_res;
      end
      chk("mem_req", mem_req, e_req);
      chk("ic_res", ic_res, e_ic);
      chk("dc_res", dc_res, e_dc);
      chk("busy", busy, m_owner != 0);
      chk("timeout_err", timeout_err, m_err);
      if (ic_res.ready) n_ic_rdy++;
      if (dc_res.ready) n_dc_rdy++;
      if (busy) begin
         n_busy++;
         if (!prev_busy) begin
            g_side.push_back((mem_req.addr == 16'h1000) ? 1 : 2);
            if (g_started) g_gap.push_back(idle_run);
            g_started = 1;
         end
         idle_run = 0;
      end else begin
         idle_run++;
      end
      prev_busy = busy;
   endtask

   // Advance the model across one rising edge with the inputs currently applied.
   task automatic model_edge();
      mem_req_type r;
      m_evt  = 0;
      m_side = m_owner;
      if (m_owner == 0) begin
         m_wait = 0;
         if (ic_req.valid && dc_req.valid) m_owner = (m_last == 1) ? 2 : 1;
         else if (ic_req.valid)            m_owner = 1;
         else if (dc_req.valid)            m_owner = 2;
      end else begin
         r = (m_owner == 1) ? ic_req : dc_req;
         if (mem_res.ready)          m_evt = 1;
         else if (!r.valid)          m_evt = 2;
         else if (m_wait + 1 == TO) begin
            m_evt = 3; m_err = 1;
         end else m_wait++;
         if (m_evt != 0) begin
            m_last = m_owner; m_owner = 0; m_wait = 0;
         end
      end
   endtask

   // Inputs are applied at the falling edge; outputs checked 1 time unit later.
   task automatic step();
      #1;
      check_out();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic clear_obs();
      n_ic_rdy = 0; n_dc_rdy = 0; n_busy = 0; idle_run = 0;
      prev_busy = 0; g_started = 0;
      g_side.delete(); g_gap.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      ic_req = '0; dc_req = '0; mem_res = '0;
      model_reset();
      clear_obs();
      #1;
      check_out();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic rnd_side(inout mem_req_type q, input int side);
      if (q.valid) begin
         if (m_side == side && m_evt == 1)                        q.valid = 1'b0;
         else if (m_side == side && m_evt == 3 && $urandom % 2 == 0) q.valid = 1'b0;
         else if ($urandom % 40 == 0)                             q.valid = 1'b0;
      end else if ($urandom % 3 == 0) begin
         q.addr  = 16'($urandom);
         q.data  = {$urandom, $urandom};
         q.rw    = 1'($urandom);
         q.valid = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got hang expected completion");
      $fatal(1, "bench hang");
   end

   initial begin
      ic_req = '0; dc_req = '0; mem_res = '0;
      model_reset();
      clear_obs();

      // Single I-cache fill, memory ready on the third busy cycle.
      do_reset();
      ic_req = '{addr: 16'h0040, data: 64'h0, rw: 1'b0, valid: 1'b1};
      for (int c = 0; c < 7; c++) begin
         mem_res = (c == 3) ? '{data: 64'hA5A5_0000_1111_2222, ready: 1'b1} : '0;
         if (c == 4) ic_req.valid = 1'b0;
         #1;
         if (c == 1) chk("t1_addr", mem_req.addr, 16'h0040);
         if (c == 3) chk("t1_data", ic_res.data, 64'hA5A5_0000_1111_2222);
         if (c == 4) chk("t1_busy_fall", busy, 1'b0);
         step();
      end
      chk("t1_ic_rdy_cnt", n_ic_rdy, 1);
      chk("t1_dc_rdy_cnt", n_dc_rdy, 0);

      // Both requesters continuously valid: strict alternation with one idle bubble.
      do_reset();
      ic_req = '{addr: 16'h1000, data: 64'h1, rw: 1'b0, valid: 1'b1};
      dc_req = '{addr: 16'h2000, data: 64'h2, rw: 1'b1, valid: 1'b1};
      for (int c = 0; c < 12; c++) begin
         mem_res = '{data: 64'(c), ready: (m_owner != 0 && m_wait == 1)};
         step();
      end
      chk("t2_ngrants", g_side.size(), 4);
      for (int i = 0; i < 4 && i < g_side.size(); i++)
         chk("t2_order", g_side[i], (i % 2 == 0) ? 1 : 2);
      for (int i = 0; i < g_gap.size(); i++)
         chk("t2_gap", g_gap[i], 1);

      // D-cache write-back passes rw and data unmodified.
      do_reset();
      dc_req = '{addr: 16'h0080, data: 64'hDEAD_BEEF_0000_0001, rw: 1'b1, valid: 1'b1};
      for (int c = 0; c < 5; c++) begin
         mem_res = '{data: 64'h55, ready: (c == 2)};
         if (c == 3) dc_req.valid = 1'b0;
         #1;
         if (c == 1) begin
            chk("t3_rw", mem_req.rw, 1'b1);
            chk("t3_wdata", mem_req.data, 64'hDEAD_BEEF_0000_0001);
         end
         step();
      end
      chk("t3_dc_rdy_cnt", n_dc_rdy, 1);
      chk("t3_ic_rdy_cnt", n_ic_rdy, 0);

      // Watchdog: memory never answers the I-cache.
      do_reset();
      ic_req = '{addr: 16'h0100, data: 64'h0, rw: 1'b0, valid: 1'b1};
      for (int c = 0; c < 10; c++) step();
      chk("t4_busy_cycles", n_busy, TO);
      chk("t4_err_set", timeout_err, 1'b1);
      ic_req.valid = 1'b0;
      dc_req = '{addr: 16'h0200, data: 64'h7, rw: 1'b0, valid: 1'b1};
      n_dc_rdy = 0;
      for (int c = 0; c < 5; c++) begin
         mem_res = '{data: 64'h99, ready: (m_owner == 2)};
         if (m_side == 2 && m_evt == 1) dc_req.valid = 1'b0;
         step();
      end
      chk("t4_dc_done", n_dc_rdy, 1);
      chk("t4_err_sticky", timeout_err, 1'b1);
      chk("t4_ic_never_rdy", n_ic_rdy, 0);

      // Asynchronous reset in the middle of a D-cache transaction.
      do_reset();
      dc_req = '{addr: 16'h0300, data: 64'h3, rw: 1'b0, valid: 1'b1};
      step();
      step();
      mem_res = '{data: 64'h77, ready: 1'b1};
      #1;
      chk("t5_pre_rdy", dc_res.ready, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      chk("t5_valid_drop", mem_req.valid, 1'b0);
      chk("t5_busy_drop", busy, 1'b0);
      chk("t5_rdy_drop", dc_res.ready, 1'b0);
      model_reset();
      mem_res = '0;
      @(negedge clk);
      rst = 1'b1;
      ic_req = '{addr: 16'h1000, data: 64'h4, rw: 1'b0, valid: 1'b1};
      step();
      #1;
      chk("t5_tie_to_i", mem_req.addr, 16'h1000);
      step();

      // Granted requester abandons its request with the other side pending.
      do_reset();
      ic_req = '{addr: 16'h1000, data: 64'h5, rw: 1'b0, valid: 1'b1};
      dc_req = '{addr: 16'h2000, data: 64'h6, rw: 1'b1, valid: 1'b1};
      for (int c = 0; c < 7; c++) begin
         if (c == 3) ic_req.valid = 1'b0;
         step();
      end
      chk("t6_order_n", g_side.size(), 2);
      if (g_side.size() == 2) begin
         chk("t6_first_i", g_side[0], 1);
         chk("t6_then_d", g_side[1], 2);
      end
      chk("t6_no_err", timeout_err, 1'b0);

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         rnd_side(ic_req, 1);
         rnd_side(dc_req, 2);
         mem_res.data  = {$urandom, $urandom};
         mem_res.ready = (m_owner != 0) ? ($urandom % 4 == 0) : 1'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single main-memory port between the instruction-cache controller and the data-cache controller. Each cache presents a line-fill/write-back request. The arbiter grants one requester at a time with round-robin fairness and holds the grant until memory answers. It steers the memory response back to the grant owner and flags hung transactions with a watchdog. It sits between the two Cache_Controller instances and the main-memory model.

Parameters:
TIMEOUT, 64, max cycles a granted transaction may wait for mem_res.ready before abort (range 2..255)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
ic_req  input  mem_req_type  instruction-cache request to memory
dc_req  input  mem_req_type  data-cache request to memory
mem_res  input  mem_data_type  main-memory response
mem_req  output  mem_req_type  request forwarded to main memory
ic_res  output  mem_data_type  response routed to instruction cache
dc_res  output  mem_data_type  response routed to data cache
busy  output  1  high while a transaction is granted
timeout_err  output  1  sticky; set on watchdog abort, cleared only by reset

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, last_grant=D (so the first tie goes to I), wdog=0, timeout_err=0.
  - mem_req.valid=0; ic_res.ready=0; dc_res.ready=0; busy=0; all data/addr fields 0.
  - Applies immediately, including mid-transaction; the in-flight memory op is abandoned.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Only ic_req.valid -> BUSY_I; only dc_req.valid -> BUSY_D.
  - Both valid -> grant the side != last_grant.
  - Neither valid -> stay in IDLE.
  - mem_res.ready is ignored in IDLE.
- BUSY_x:
  - mem_req = x_req (combinational pass-through, so valid is visible in the first BUSY cycle); busy=1.
  - x_res.data = mem_res.data and x_res.ready = mem_res.ready.
  - The non-granted side sees ready=0, data=0.
- Completion:
  - mem_res.ready=1 in BUSY_x -> IDLE next cycle, last_grant<=x, wdog<=0.
  - One mandatory IDLE bubble separates back-to-back grants.
- Latency: request first valid at edge N -> mem_req.valid at cycle N+1 (after the grant edge). The response reaches the requester in the same cycle memory asserts ready.
- Abort: if the granted requester drops valid before ready (protocol violation) -> IDLE next cycle; last_grant<=x; no error flagged.
- Watchdog:
  - wdog is 8-bit and increments each BUSY cycle without ready.
  - When wdog reaches TIMEOUT-1 and ready is still 0: timeout_err<=1, go to IDLE, last_grant<=x, wdog<=0.
  - The requester never receives ready for that op.
- Simultaneous events: ready and requester-drop in the same cycle count as completion (ready wins). A new request arriving during BUSY waits; it is not queued beyond the request-hold convention.
- Requester rule: requesters hold the request stable until ready. The arbiter does not latch request fields.
- rw and addr are passed through unmodified. The arbiter never alters memory semantics.
- Fairness: with both requesters continuously valid, grants strictly alternate I, D, I, D.

Decomposition:
- mem_req_type and mem_data_type come from the shared package icache_def:
  - mem_req_type = {addr[15:0], data[63:0], rw, valid}
  - mem_data_type = {data[63:0], ready}
- Add to the shared package:
  - enum arb_state_t {IDLE, BUSY_I, BUSY_D}
  - enum requester_t {REQ_I, REQ_D}
- No sub-module; the FSM, round-robin pointer and watchdog are one module. The response/request steering muxes are plain always_comb.

Test Plan:
- Reset release, ic_req.valid=1 addr=16'h0040 rw=0; memory ready after 3 cycles with data=64'hA5A5_0000_1111_2222 -> mem_req.addr=16'h0040 from cycle 1; ic_res.ready=1 with that data exactly once; dc_res.ready stays 0; busy falls the next cycle.
- ic_req and dc_req valid in the same cycle after reset, memory ready after 2 cycles each -> grant order I, D, I, D over 4 transactions; exactly one IDLE cycle between each.
- dc_req only, rw=1, data=64'hDEAD_BEEF_0000_0001 -> mem_req carries rw=1 and that data; dc_res.ready pulses once; ic_res stays 0.
- TIMEOUT=8, ic_req valid, memory never ready -> exactly 8 BUSY_I cycles, then IDLE; timeout_err=1 and remains 1 while a following dc_req completes normally.
- rst driven low mid BUSY_D, asynchronously between edges -> mem_req.valid, busy and dc_res.ready drop to 0 without waiting for a clock edge; after release the first tie grants I.
- Granted ic_req drops valid after 2 BUSY cycles with dc_req pending -> IDLE, then BUSY_D; timeout_err stays 0.
